clk_divider_multi: RTL and testbench
====================================

# clk_divider_multi

Parametrised multi-channel clock divider and tick generator, the successor to our fixed single-channel 1 Hz divider. Each of CHANNELS channels produces a 50 %-duty divided clock and a one-cycle tick from the board clock. Each channel's half-period can be reprogrammed at runtime, with glitch-free hand-over at the toggle boundary. Enable and global phase-sync controls are provided. It feeds display multiplexing, debouncers and slow LED/timer logic.

## Interface

**Parameters**
- CHANNELS, default 4: number of independent divider channels.
- WIDTH, default 26: width of the half-period counter and divisor.
- DEFAULT_HALF, default 50000000: half-period loaded at reset (1 Hz from 100 MHz). Must be ≥1 and <2^WIDTH.

**Ports**
- clk_i, input, 1: system clock; all logic on its rising edge.
- rst_n_i, input, 1: reset; synchronous, active-low.
- en_i, input, CHANNELS: per-channel run enable.
- load_i, input, CHANNELS: per-channel load strobe, sampling div_i.
- div_i, input, WIDTH: new half-period value, shared by all channels.
- sync_i, input, 1: restarts all channels in phase.
- clk_o, output, CHANNELS: divided clocks. Registered; fabric use only, not a global clock.
- tick_o, output, CHANNELS: one-cycle pulse coincident with each rising edge of clk_o.
- pend_o, output, CHANNELS: 1 while a loaded divisor is waiting to take effect.

## Operation

**Per-channel state**
- half register H (WIDTH bits)
- pending register P plus pending flag
- counter cnt (WIDTH bits)
- output register clk_o
- tick register tick_o

**Reset (rst_n_i=0 at an edge)**
- H=DEFAULT_HALF, cnt=0, clk_o=0, tick_o=0, pend_o=0.
- All outputs read 0 in the cycle after the reset edge.

**Divisor clamp**
- A div_i value of 0 is clamped to 1 wherever it is captured.
- H is always ≥1.

**Running (en_i[c]=1, no sync)**
- If cnt<H-1: cnt increments.
- If cnt==H-1 (wrap): cnt←0 and clk_o toggles.
  - tick_o←1 when clk_o goes 0→1; otherwise tick_o←0.
- Resulting period is 2·H clk_i cycles, high for exactly H cycles.

**Disabled (en_i[c]=0)**
- cnt←0, clk_o←0, tick_o←0.
- A load writes H directly; pend_o stays 0.

**Load while running**
- Default case: load_i[c]=1 captures the clamped div_i into P and sets pend_o.
- At the next wrap, H←P and pend_o clears. The new value governs the half-period starting at that wrap.
- Load on a wrap edge: if load_i[c]=1 on the same edge as a wrap, the clamped div_i goes straight into H and pend_o stays or becomes 0.
- A second load before the wrap overwrites P; the last value wins.
- H never changes mid-half-period, so no runt pulses.

**sync_i=1**
- All channels: cnt←0, clk_o←0, tick_o←0.
- A pending P is applied to H immediately and pend_o clears.
- A simultaneous load_i writes H directly.
- Priority: reset > sync_i > en_i=0 > load/run.

**Arithmetic**
- cnt compares only against H-1. Since cnt<H always holds, there is no overflow or wrap beyond 2^WIDTH.

## Timing

- Enable to first rise: from the first edge where en_i[c] is sampled 1 with cnt=0, clk_o rises at the H-th such edge; tick_o is high the same cycle.
- H=1: clk_o toggles every cycle (period 2), and tick_o is high every other cycle.
- Enable drop: dropping en_i forces clk_o=0 one edge later, even mid-high.
- pend_o:
  - rises the cycle after the load edge;
  - falls the cycle after the wrap edge that applies P.
- Sync: after a sync_i edge, all enabled channels with equal H rise together H edges later.
- Reset mid-operation discards P and restores DEFAULT_HALF.
- All outputs are registered, with no combinational input-to-output paths.

## Test plan

- **Reset defaults:** DEFAULT_HALF=5. Reset, then en_i=1 → clk_o[0] rises 5 cycles after enable and has period 10; tick_o is one cycle wide every 10 cycles; pend_o=0.
- **Minimum divisor:** load 0 on channel 1 while disabled, then enable → clamped to H=1; clk_o[1] alternates every cycle; tick_o[1] is high every other cycle.
- **Glitch-free reload:** H=5, running. Load 2 at cnt=1 → pend_o=1 until the wrap; the current half-period stays 5 cycles, then halves are 2 cycles; pend_o drops after the wrap.
- **Load on a wrap edge:** load 3 exactly on a wrap edge → the next half-period is 3 cycles; pend_o never asserts.
- **Sync alignment:** channels at H=4 and H=6, out of phase. Pulse sync_i → both clk_o are 0 the next cycle; ch0 rises at +4 and ch1 at +6 edges; the ch0 and ch1 tick_o pulses coincide every 24 cycles.
- **Disable and reset mid-operation:** drop en_i while clk_o=1 → clk_o=0 the next cycle, and re-enable restarts the count from 0. Assert rst_n_i=0 with a pending load → all outputs are 0, the pending value is discarded, and H=DEFAULT_HALF.

Source files
------------

// File: rtl/clk_divider_multi.sv
// ============================================================================
// clk_divider_multi
// ----------------------------------------------------------------------------
// Purpose:
//    Multi-channel clock divider and tick generator. Each channel divides the
//    board clock by 2*H, where H is a per-channel half-period register. The
//    output is a 50 % duty divided clock plus a one-cycle tick on each of its
//    rising edges. H can be reprogrammed at runtime. While a channel runs, a
//    new value waits in a pending register and takes effect only at the next
//    toggle boundary, so the output never produces runt pulses.
//
// Ports:
//    clk_i    - system clock, all logic on its rising edge
//    rst_n_i  - synchronous active-low reset
//    en_i     - per-channel run enable
//    load_i   - per-channel load strobe, samples div_i
//    div_i    - new half-period value shared by all channels (0 is taken as 1)
//    sync_i   - restarts every channel in phase
//    clk_o    - registered divided clocks (fabric use, not a global clock)
//    tick_o   - one-cycle pulse coincident with each rising edge of clk_o
//    pend_o   - high while a loaded half-period waits for its toggle boundary
// ============================================================================
module clk_divider_multi #(
   parameter int          CHANNELS     = 4,
   parameter int          WIDTH        = 26,
   parameter int unsigned DEFAULT_HALF = 50000000
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic [CHANNELS-1:0] en_i,
   input  logic [CHANNELS-1:0] load_i,
   input  logic [WIDTH-1:0]    div_i,
   input  logic                sync_i,
   output logic [CHANNELS-1:0] clk_o,
   output logic [CHANNELS-1:0] tick_o,
   output logic [CHANNELS-1:0] pend_o
);

   localparam logic [WIDTH-1:0] DefHalf = WIDTH'(DEFAULT_HALF);
   localparam logic [WIDTH-1:0] One     = WIDTH'(1);

   logic [WIDTH-1:0]    half_q    [CHANNELS];
   logic [WIDTH-1:0]    half_d    [CHANNELS];
   logic [WIDTH-1:0]    pendVal_q [CHANNELS];
   logic [WIDTH-1:0]    pendVal_d [CHANNELS];
   logic [WIDTH-1:0]    cnt_q     [CHANNELS];
   logic [WIDTH-1:0]    cnt_d     [CHANNELS];
   logic [CHANNELS-1:0] pend_q;
   logic [CHANNELS-1:0] pend_d;
   logic [CHANNELS-1:0] clk_q;
   logic [CHANNELS-1:0] clk_d;
   logic [CHANNELS-1:0] tick_q;
   logic [CHANNELS-1:0] tick_d;
   logic [WIDTH-1:0]    divClamped;

   // A zero divisor would make H-1 underflow, so it is captured as 1.
   assign divClamped = (div_i == '0) ? One : div_i;

   // Next-state logic for every channel. Sync and disable both park the
   // counter at 0, so any half-period change is safe there and a waiting
   // value is applied at once. While running, H only changes on a wrap edge.
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         half_d[c]    = half_q[c];
         pendVal_d[c] = pendVal_q[c];
         cnt_d[c]     = cnt_q[c];
         pend_d[c]    = pend_q[c];
         clk_d[c]     = clk_q[c];
         tick_d[c]    = 1'b0;

         if (sync_i || !en_i[c]) begin
            cnt_d[c]  = '0;
            clk_d[c]  = 1'b0;
            pend_d[c] = 1'b0;
            if (load_i[c]) begin
               half_d[c] = divClamped;
            end else if (pend_q[c]) begin
               half_d[c] = pendVal_q[c];
            end
         end else if (cnt_q[c] == half_q[c] - One) begin
            cnt_d[c]  = '0;
            clk_d[c]  = ~clk_q[c];
            tick_d[c] = ~clk_q[c];
            pend_d[c] = 1'b0;
            if (load_i[c]) begin
               half_d[c] = divClamped;
            end else if (pend_q[c]) begin
               half_d[c] = pendVal_q[c];
            end
         end else begin
            cnt_d[c] = cnt_q[c] + One;
            if (load_i[c]) begin
               pendVal_d[c] = divClamped;
               pend_d[c]    = 1'b1;
            end
         end
      end
   end

   // State registers with synchronous active-low reset; reset drops any
   // pending value and restores the default half-period.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int c = 0; c < CHANNELS; c++) begin
            half_q[c]    <= DefHalf;
            pendVal_q[c] <= DefHalf;
            cnt_q[c]     <= '0;
         end
         pend_q <= '0;
         clk_q  <= '0;
         tick_q <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            half_q[c]    <= half_d[c];
            pendVal_q[c] <= pendVal_d[c];
            cnt_q[c]     <= cnt_d[c];
         end
         pend_q <= pend_d;
         clk_q  <= clk_d;
         tick_q <= tick_d;
      end
   end

   assign clk_o  = clk_q;
   assign tick_o = tick_q;
   assign pend_o = pend_q;

endmodule

// File: tb/tb_clk_divider_multi.sv
// ============================================================================
// tb_clk_divider_multi
// ----------------------------------------------------------------------------
// Purpose:
//    Self-checking bench for clk_divider_multi. An event-based model predicts
//    each channel's next toggle time from its half-period, and its outputs
//    are compared with the DUT every cycle. Directed sequences with
//    hand-computed literal expectations come first, followed by randomized
//    traffic.
// ============================================================================
module tb_clk_divider_multi;

   localparam int CH  = 4;
   localparam int W   = 8;
   localparam int DEF = 5;

   logic          clk;
   logic          rstN;
   logic [CH-1:0] en;
   logic [CH-1:0] load;
   logic [W-1:0]  div;
   logic          sync;
   logic [CH-1:0] clkOut;
   logic [CH-1:0] tickOut;
   logic [CH-1:0] pendOut;

   int nVectors     = 0;
   int nMiscompares = 0;

   clk_divider_multi #(
      .CHANNELS     (CH),
      .WIDTH        (W),
      .DEFAULT_HALF (DEF)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rstN),
      .en_i    (en),
      .load_i  (load),
      .div_i   (div),
      .sync_i  (sync),
      .clk_o   (clkOut),
      .tick_o  (tickOut),
      .pend_o  (pendOut)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model state: each running channel remembers the absolute cycle at which
   // its next toggle happens, instead of counting.
   longint cyc = 0;
   bit     modelValid = 0;
   int     mHalf [CH];
   int     mPendVal [CH];
   bit     mPend [CH];
   bit     mRun [CH];
   bit     mLvl [CH];
   bit     mTick [CH];
   longint mAt [CH];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nVectors++;
      if (actual !== expected) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Model update on each rising edge, then a per-cycle comparison shortly
   // after the edge once the DUT registers have settled.
   always @(posedge clk) begin
      int dv;
      cyc++;
      dv = (div == '0) ? 1 : int'(div);
      for (int c = 0; c < CH; c++) begin
         if (!rstN) begin
            mHalf[c] = DEF;
            mPend[c] = 0;
            mRun[c]  = 0;
            mLvl[c]  = 0;
            mTick[c] = 0;
         end else if (sync || !en[c]) begin
            mRun[c]  = 0;
            mLvl[c]  = 0;
            mTick[c] = 0;
            if (load[c]) mHalf[c] = dv;
            else if (mPend[c]) mHalf[c] = mPendVal[c];
            mPend[c] = 0;
         end else begin
            if (!mRun[c]) begin
               mRun[c] = 1;
               mAt[c]  = cyc + longint'(mHalf[c]) - 1;
            end
            if (cyc == mAt[c]) begin
               mLvl[c]  = !mLvl[c];
               mTick[c] = mLvl[c];
               if (load[c]) mHalf[c] = dv;
               else if (mPend[c]) mHalf[c] = mPendVal[c];
               mPend[c] = 0;
               mAt[c]   = cyc + longint'(mHalf[c]);
            end else begin
               mTick[c] = 0;
               if (load[c]) begin
                  mPendVal[c] = dv;
                  mPend[c]    = 1;
               end
            end
         end
      end
      if (!rstN) modelValid = 1;
      #1;
      if (modelValid) begin
         for (int c = 0; c < CH; c++) begin
            checkOutput($sformatf("model ch%0d cyc%0d {clk,tick,pend}", c, cyc),
                        {29'd0, clkOut[c], tickOut[c], pendOut[c]},
                        {29'd0, mLvl[c], mTick[c], mPend[c]});
         end
      end
   end

   // Drives one set of inputs just after a falling edge and holds them for
   // the requested number of cycles, returning on a falling edge.
   task automatic applyStimulus(input logic r, input logic [CH-1:0] e,
                                input logic [CH-1:0] l, input int d,
                                input logic s, input int cycles);
      rstN = r;
      en   = e;
      load = l;
      div  = W'(d);
      sync = s;
      repeat (cycles) @(negedge clk);
   endtask

   initial begin
      rstN = 1'b0; en = '0; load = '0; div = '0; sync = 1'b0;
      @(negedge clk);

      // Reset defaults
      applyStimulus(0, 4'b0000, 4'b0000, 0, 0, 2);
      checkOutput("reset clk_o",  32'(clkOut),  32'h0);
      checkOutput("reset tick_o", 32'(tickOut), 32'h0);
      checkOutput("reset pend_o", 32'(pendOut), 32'h0);

      // Default half-period 5: rise on the 5th enabled edge, period 10
      applyStimulus(1, 4'b0001, 4'b0000, 0, 0, 4);
      checkOutput("en ch0 before rise", 32'(clkOut[0]), 32'h0);
      applyStimulus(1, 4'b0001, 4'b0000, 0, 0, 1);
      checkOutput("en ch0 rise clk",  32'(clkOut[0]),  32'h1);
      checkOutput("en ch0 rise tick", 32'(tickOut[0]), 32'h1);
      applyStimulus(1, 4'b0001, 4'b0000, 0, 0, 1);
      checkOutput("ch0 tick one wide", 32'(tickOut[0]), 32'h0);
      applyStimulus(1, 4'b0001, 4'b0000, 0, 0, 3);
      checkOutput("ch0 high 5 cycles", 32'(clkOut[0]), 32'h1);
      applyStimulus(1, 4'b0001, 4'b0000, 0, 0, 1);
      checkOutput("ch0 fall", 32'(clkOut[0]), 32'h0);
      applyStimulus(1, 4'b0001, 4'b0000, 0, 0, 5);
      checkOutput("ch0 period 10 clk",  32'(clkOut[0]),  32'h1);
      checkOutput("ch0 period 10 tick", 32'(tickOut[0]), 32'h1);
      checkOutput("ch0 pend", 32'(pendOut[0]), 32'h0);

      // Minimum divisor: load 0 while disabled is taken as 1
      applyStimulus(1, 4'b0001, 4'b0010, 0, 0, 1);
      checkOutput("ch1 disabled load pend", 32'(pendOut[1]), 32'h0);
      applyStimulus(1, 4'b0011, 4'b0000, 0, 0, 1);
      checkOutput("ch1 H=1 first clk",  32'(clkOut[1]),  32'h1);
      checkOutput("ch1 H=1 first tick", 32'(tickOut[1]), 32'h1);
      applyStimulus(1, 4'b0011, 4'b0000, 0, 0, 1);
      checkOutput("ch1 H=1 low", 32'({clkOut[1], tickOut[1]}), 32'h0);
      applyStimulus(1, 4'b0011, 4'b0000, 0, 0, 1);
      checkOutput("ch1 H=1 high", 32'({clkOut[1], tickOut[1]}), 32'h3);

      // Glitch-free reload on ch2 (H=5): load 2 while cnt=1
      applyStimulus(1, 4'b0111, 4'b0000, 0, 0, 1);
      applyStimulus(1, 4'b0111, 4'b0100, 2, 0, 1);
      checkOutput("ch2 pend after load", 32'(pendOut[2]), 32'h1);
      applyStimulus(1, 4'b0111, 4'b0000, 0, 0, 2);
      checkOutput("ch2 old half kept", 32'({clkOut[2], pendOut[2]}), 32'h1);
      applyStimulus(1, 4'b0111, 4'b0000, 0, 0, 1);
      checkOutput("ch2 wrap applies", 32'({clkOut[2], pendOut[2]}), 32'h2);
      applyStimulus(1, 4'b0111, 4'b0000, 0, 0, 1);
      checkOutput("ch2 new half 2a", 32'(clkOut[2]), 32'h1);
      applyStimulus(1, 4'b0111, 4'b0000, 0, 0, 1);
      checkOutput("ch2 new half 2b", 32'(clkOut[2]), 32'h0);

      // Load 3 exactly on the wrap edge that raises ch2
      applyStimulus(1, 4'b0111, 4'b0000, 0, 0, 1);
      applyStimulus(1, 4'b0111, 4'b0100, 3, 0, 1);
      checkOutput("ch2 wrap load", 32'({clkOut[2], pendOut[2]}), 32'h2);
      applyStimulus(1, 4'b0111, 4'b0000, 0, 0, 2);
      checkOutput("ch2 half 3 held", 32'({clkOut[2], pendOut[2]}), 32'h2);
      applyStimulus(1, 4'b0111, 4'b0000, 0, 0, 1);
      checkOutput("ch2 half 3 fall", 32'(clkOut[2]), 32'h0);

      // Sync alignment with ch0 H=4, ch1 H=6
      applyStimulus(1, 4'b0000, 4'b0001, 4, 0, 1);
      applyStimulus(1, 4'b0000, 4'b0010, 6, 0, 1);
      applyStimulus(1, 4'b0011, 4'b0000, 0, 0, 3);
      applyStimulus(1, 4'b0011, 4'b0000, 0, 1, 1);
      checkOutput("sync clears", 32'(clkOut[1:0]), 32'h0);
      applyStimulus(1, 4'b0011, 4'b0000, 0, 0, 3);
      checkOutput("sync +3", 32'(clkOut[1:0]), 32'h0);
      applyStimulus(1, 4'b0011, 4'b0000, 0, 0, 1);
      checkOutput("sync +4 clk",  32'(clkOut[1:0]),  32'h1);
      checkOutput("sync +4 tick", 32'(tickOut[1:0]), 32'h1);
      applyStimulus(1, 4'b0011, 4'b0000, 0, 0, 2);
      checkOutput("sync +6 clk",  32'(clkOut[1:0]),  32'h3);
      checkOutput("sync +6 tick", 32'(tickOut[1:0]), 32'h2);

      // Disable mid-high, then re-enable restarts from 0
      applyStimulus(1, 4'b0010, 4'b0000, 0, 0, 1);
      checkOutput("disable forces low", 32'(clkOut[0]), 32'h0);
      applyStimulus(1, 4'b0011, 4'b0000, 0, 0, 3);
      checkOutput("reenable +3", 32'(clkOut[0]), 32'h0);
      applyStimulus(1, 4'b0011, 4'b0000, 0, 0, 1);
      checkOutput("reenable +4", 32'(clkOut[0]), 32'h1);

      // Reset with a pending load discards it
      applyStimulus(1, 4'b1011, 4'b0000, 0, 0, 1);
      applyStimulus(1, 4'b1011, 4'b1000, 9, 0, 1);
      checkOutput("ch3 pending", 32'(pendOut[3]), 32'h1);
      applyStimulus(0, 4'b1011, 4'b0000, 0, 0, 1);
      checkOutput("midreset outputs", 32'({clkOut, tickOut, pendOut}), 32'h0);
      applyStimulus(1, 4'b1000, 4'b0000, 0, 0, 4);
      checkOutput("ch3 default +4", 32'(clkOut[3]), 32'h0);
      applyStimulus(1, 4'b1000, 4'b0000, 0, 0, 1);
      checkOutput("ch3 default +5", 32'({clkOut[3], tickOut[3]}), 32'h3);

      // Randomized traffic, checked against the model every cycle
      for (int i = 0; i < 4000; i++) begin
         logic [CH-1:0] e;
         logic [CH-1:0] l;
         e = en;
         l = '0;
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(31) == 0) e[c] = ~e[c];
            if ($urandom_range(11) == 0) l[c] = 1'b1;
         end
         applyStimulus(($urandom_range(299) != 0), e, l,
                       int'($urandom_range(7)),
                       ($urandom_range(149) == 0), 1);
      end

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
